// File: rtl/aes_key_expand_seq_pkg.sv
// rtl/aes_key_expand_seq_pkg.sv - shared types, constants and helpers for the AES key schedule
package aes_key_expand_seq_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    // Forward S-box, entry 0 in the most-significant byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int aes_nw(input int nr);
        return 4 * (nr + 1);
    endfunction

    function automatic bit aes_legal(input int nk, input int nr);
        return (nk == 4 && nr == 10) || (nk == 6 && nr == 12) || (nk == 8 && nr == 14);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[2047 - 8 * int'(b) -: 8];
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_sub_word.sv
// rtl/aes_key_expand_seq_sub_word.sv - combinational SubWord: four forward S-box lookups
module aes_sub_word
    import aes_key_expand_seq_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES key expansion, one schedule word per clock
module aes_key_expand_seq
    import aes_key_expand_seq_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [Nk*32-1:0]        key,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic [128*(Nr+1)-1:0]   key_out
);

    localparam int         NW     = aes_nw(Nr);
    localparam int         KW     = 128 * (Nr + 1);
    localparam logic [5:0] NK_W   = 6'(Nk);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] J_MAX  = 3'(Nk - 1);

    if (!aes_legal(Nk, Nr)) begin : g_bad_params
        $error("aes_key_expand_seq: illegal (Nk,Nr) pair");
    end

    state_e      state_q;
    logic        busy_q, done_q, valid_q;
    logic [31:0] w_q [NW];
    logic [5:0]  idx_q;
    logic [2:0]  j_q;
    logic [7:0]  rcon_q;

    logic [31:0] t_w, rot_w, sub_in, sub_out, temp_w, w_d;

    // One shared SubWord serves both the rotated (j==0) and the AES-256 j==4 case.
    always_comb begin
        t_w    = w_q[idx_q - 6'd1];
        rot_w  = {t_w[23:0], t_w[31:24]};
        sub_in = (j_q == 3'd0) ? rot_w : t_w;
        if (j_q == 3'd0) begin
            temp_w = sub_out ^ {rcon_q, 24'h0};
        end else if (Nk == 8 && j_q == 3'd4) begin
            temp_w = sub_out;
        end else begin
            temp_w = t_w;
        end
        w_d = w_q[idx_q - NK_W] ^ temp_w;
    end

    aes_sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            j_q     <= '0;
            rcon_q  <= RCON_INIT;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < Nk; k++) begin
                            w_q[k] <= key[Nk*32-1-32*k -: 32];
                        end
                        idx_q   <= NK_W;
                        j_q     <= '0;
                        rcon_q  <= RCON_INIT;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    w_q[idx_q] <= w_d;
                    idx_q      <= idx_q + 6'd1;
                    j_q        <= (j_q == J_MAX) ? 3'd0 : j_q + 3'd1;
                    if (j_q == 3'd0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    if (idx_q == LAST_W) begin
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NW; g++) begin : g_key_out
        assign key_out[KW-1-32*g -: 32] = w_q[g];
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - vector, random and corner-case checks of the sequential key schedule
module tb_aes_key_expand_seq;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        int           sel;
        logic [255:0] key;
        int           idx;
        logic [31:0]  word;
        int           lat;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [2:0]     start_drv;
    logic [255:0]   key_drv;
    logic [2:0]     busy_o, done_o, valid_o;
    logic [1407:0]  ko128;
    logic [1663:0]  ko192;
    logic [1919:0]  ko256;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sb  [256];
    logic [7:0]  isb [256];
    logic [31:0] rw  [60];

    always #5 clk = ~clk;

    aes_key_expand_seq #(.Nk(4), .Nr(10)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start(start_drv[0]), .key(key_drv[255:128]),
        .busy(busy_o[0]), .done(done_o[0]), .valid(valid_o[0]), .key_out(ko128));
    aes_key_expand_seq #(.Nk(6), .Nr(12)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .start(start_drv[1]), .key(key_drv[255:64]),
        .busy(busy_o[1]), .done(done_o[1]), .valid(valid_o[1]), .key_out(ko192));
    aes_key_expand_seq #(.Nk(8), .Nr(14)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .start(start_drv[2]), .key(key_drv),
        .busy(busy_o[2]), .done(done_o[2]), .valid(valid_o[2]), .key_out(ko256));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then the affine map.
    function automatic void build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic void ref_sched(input int nk, input int nr, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 60; i++) rw[i] = 32'h0;
        for (int i = 0; i < nk; i++) rw[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = rw[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int p = 1; p < i / nk; p++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            rw[i] = rw[i-nk] ^ t;
        end
    endfunction

    function automatic logic [31:0] dut_word(input int sel, input int i);
        case (sel)
            0:       return ko128[1407-32*i -: 32];
            1:       return ko192[1663-32*i -: 32];
            default: return ko256[1919-32*i -: 32];
        endcase
    endfunction

    function automatic logic [127:0] rk(input int r);
        return ko128[1407-128*r -: 128];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv ? isb[s[127-8*k -: 8]] : sb[s[127-8*k -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k-r+4)%4], s[127-8*(k+4*c) -: 8]);
                o[127-8*(r+4*c) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] p);
        logic [127:0] st;
        st = p ^ rk(0);
        for (int r = 1; r <= 10; r++) begin
            st = shift_rows(sub_bytes(st, 1'b0), 1'b0);
            if (r < 10) st = mix_cols(st, 1'b0);
            st = st ^ rk(r);
        end
        return st;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] c);
        logic [127:0] st;
        st = c ^ rk(10);
        for (int r = 9; r >= 0; r--) begin
            st = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk(r);
            if (r > 0) st = mix_cols(st, 1'b1);
        end
        return st;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_sched(input int sel, input logic [255:0] k, input string name);
        int bad;
        bad = 0;
        ref_sched(4 + 2 * sel, 10 + 2 * sel, k);
        for (int i = 0; i < 4 * (11 + 2 * sel); i++)
            if (dut_word(sel, i) !== rw[i]) bad++;
        chk(name, 128'(bad), 128'd0);
    endtask

    task automatic pulse_start(input int sel, input logic [255:0] k);
        key_drv        = k;
        start_drv[sel] = 1'b1;
        @(posedge clk); #1;
        start_drv[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        while (done_o[sel] !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        vec_t         vt [7];
        int           cyc, sel;
        logic [255:0] kr;

        vt[0] = '{0, K128, 4,  32'ha0fafe17, 40};
        vt[1] = '{0, K128, 43, 32'hb6630ca6, 40};
        vt[2] = '{1, K192, 6,  32'hfe0c91f7, 46};
        vt[3] = '{1, K192, 51, 32'h01002202, 46};
        vt[4] = '{2, K256, 8,  32'h9ba35411, 52};
        vt[5] = '{2, K256, 12, 32'ha8b09c1a, 52};
        vt[6] = '{2, K256, 59, 32'h706c631e, 52};

        build_tables();
        rst_n     = 1'b0;
        start_drv = 3'b000;
        key_drv   = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_busy%0d", s),  128'(busy_o[s]),  128'd0);
            chk($sformatf("rst_done%0d", s),  128'(done_o[s]),  128'd0);
            chk($sformatf("rst_valid%0d", s), 128'(valid_o[s]), 128'd0);
        end
        chk("rst_keyout", 128'(|{ko128, ko192, ko256}), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            pulse_start(vt[v].sel, vt[v].key);
            wait_done(vt[v].sel, cyc);
            chk($sformatf("vec%0d_lat", v),  128'(cyc), 128'(vt[v].lat));
            chk($sformatf("vec%0d_word", v), 128'(dut_word(vt[v].sel, vt[v].idx)), 128'(vt[v].word));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", v), 128'(done_o[vt[v].sel]),  128'd0);
            chk($sformatf("vec%0d_valid_hold", v), 128'(valid_o[vt[v].sel]), 128'd1);
        end

        for (int n = 0; n < 6; n++) begin
            sel = n % 3;
            kr  = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            pulse_start(sel, kr);
            wait_done(sel, cyc);
            chk($sformatf("rand%0d_lat", n), 128'(cyc), 128'(4 * (11 + 2 * sel) - (4 + 2 * sel)));
            check_sched(sel, kr, $sformatf("rand%0d_sched", n));
        end

        pulse_start(0, K128);
        cyc = 0;
        repeat (9) begin @(posedge clk); #1; cyc++; end
        key_drv      = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        start_drv[0] = 1'b1;
        @(posedge clk); #1;
        cyc++;
        start_drv[0] = 1'b0;
        while (done_o[0] !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("restart_lat", 128'(cyc), 128'd40);
        check_sched(0, K128, "restart_sched");

        pulse_start(0, K128);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", 128'(busy_o[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   128'(busy_o[0]),  128'd0);
        chk("abort_valid",  128'(valid_o[0]), 128'd0);
        chk("abort_keyout", 128'(|ko128),     128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start(0, K128);
        wait_done(0, cyc);
        chk("post_rst_lat", 128'(cyc), 128'd40);
        check_sched(0, K128, "post_rst_sched");

        chk("cipher", aes_enc(PT), CT);
        chk("inv_cipher", aes_dec(aes_enc(PT)), PT);

        chk("b2b_done", 128'(done_o[0]), 128'd1);
        kr = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        pulse_start(0, kr);
        chk("b2b_valid_drop", 128'(valid_o[0]), 128'd0);
        chk("b2b_busy",       128'(busy_o[0]),  128'd1);
        wait_done(0, cyc);
        chk("b2b_lat", 128'(cyc), 128'd40);
        check_sched(0, kr, "b2b_sched");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
